// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: turns hazard, branch, memory-handshake and halt
// events into per-stage enable/clear strobes, with a memory-wait timeout and perf counters.
module pipe_stall_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bubble_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    input  logic             halt_i,
    output logic             pc_en_o,
    output logic             fd_en_o,
    output logic             dx_en_o,
    output logic             xm_en_o,
    output logic             mw_en_o,
    output logic             fd_clear_o,
    output logic             dx_clear_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             mem_err_o,
    output logic             halted_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next, wait_inc;
    logic              freeze;
    logic              stall_inc, flush_inc, err_set;

    assign freeze   = mem_req_i & ~mem_ack_i;
    assign wait_inc = wait_cnt + 1'b1;
    assign halted_o = (state == HALTED);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pc_en_o    = 1'b0;
        fd_en_o    = 1'b0;
        dx_en_o    = 1'b0;
        xm_en_o    = 1'b0;
        mw_en_o    = 1'b0;
        fd_clear_o = 1'b0;
        dx_clear_o = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        err_set    = 1'b0;
        state_next = state;
        wait_next  = wait_cnt;

        if (state != HALTED) begin
            if (freeze) begin
                stall_inc = 1'b1;
            end else if (branch_taken_i) begin
                {pc_en_o, fd_en_o, dx_en_o, xm_en_o, mw_en_o} = '1;
                fd_clear_o = 1'b1;
                dx_clear_o = 1'b1;
                flush_inc  = 1'b1;
            end else if (bubble_i) begin
                dx_clear_o = 1'b1;
                xm_en_o    = 1'b1;
                mw_en_o    = 1'b1;
                stall_inc  = 1'b1;
            end else begin
                {pc_en_o, fd_en_o, dx_en_o, xm_en_o, mw_en_o} = '1;
            end
        end

        case (state)
            RUN: begin
                if (freeze) begin
                    state_next = MEM_WAIT;
                    wait_next  = '0;
                end else if (halt_i) begin
                    state_next = HALTED;
                end
            end
            MEM_WAIT: begin
                if (freeze) begin
                    // Timeout fires on the edge where the count would reach its last value.
                    if (wait_inc == WAIT_LAST) begin
                        state_next = HALTED;
                        err_set    = 1'b1;
                    end else begin
                        wait_next = wait_inc;
                    end
                end else if (halt_i) begin
                    state_next = HALTED;
                end else begin
                    state_next = RUN;
                end
            end
            default: state_next = HALTED;
        endcase

        // Reset forces NOPs into FD/DX and holds every stage.
        if (reset) begin
            {pc_en_o, fd_en_o, dx_en_o, xm_en_o, mw_en_o} = '0;
            fd_clear_o = 1'b1;
            dx_clear_o = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
            mem_err_o   <= 1'b0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_next;
            mem_err_o <= mem_err_o | err_set;
            if (stall_inc && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + 1'b1;
            if (flush_inc && (flush_cnt_o != '1))
                flush_cnt_o <= flush_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: a cycle-level reference model pushes expected
// outputs into a queue; a negedge monitor pops and compares them against the DUT.
module tb_pipe_stall_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset, bubble_i, branch_taken_i, mem_req_i, mem_ack_i, halt_i;
    logic pc_en_o, fd_en_o, dx_en_o, xm_en_o, mw_en_o, fd_clear_o, dx_clear_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
    logic mem_err_o, halted_o;

    pipe_stall_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .bubble_i(bubble_i), .branch_taken_i(branch_taken_i),
        .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i), .halt_i(halt_i),
        .pc_en_o(pc_en_o), .fd_en_o(fd_en_o), .dx_en_o(dx_en_o), .xm_en_o(xm_en_o),
        .mw_en_o(mw_en_o), .fd_clear_o(fd_clear_o), .dx_clear_o(dx_clear_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
        .mem_err_o(mem_err_o), .halted_o(halted_o)
    );

    always #5 clk = ~clk;

    // {pc,fd,dx,xm,mw,fd_clr,dx_clr, stall[3:0], flush[3:0], err, halted}
    typedef logic [16:0] obs_t;
    obs_t exp_q[$];

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    // Reference model: counts, a consecutive-freeze run length and a halted flag.
    int m_stall = 0, m_flush = 0, m_run = 0;
    bit m_err = 0, m_halted = 0;
    int mem_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
        end
    endtask

    task automatic step(input bit rst, input bit bub, input bit br, input bit req,
                        input bit ack, input bit hlt);
        bit   frz;
        logic [6:0] s;
        @(posedge clk);
        #1;
        reset = rst; bubble_i = bub; branch_taken_i = br;
        mem_req_i = req; mem_ack_i = ack; halt_i = hlt;
        frz = req && !ack;
        if (rst)            s = 7'b00000_11;
        else if (m_halted)  s = 7'b00000_00;
        else if (frz)       s = 7'b00000_00;
        else if (br)        s = 7'b11111_11;
        else if (bub)       s = 7'b00011_01;
        else                s = 7'b11111_00;
        exp_q.push_back({s, 4'(m_stall), 4'(m_flush), m_err, m_halted});

        if (rst) begin
            m_stall = 0; m_flush = 0; m_run = 0; m_err = 0; m_halted = 0;
        end else if (!m_halted) begin
            if ((frz || (!br && bub)) && m_stall < CNT_MAX) m_stall++;
            if (!frz && br && m_flush < CNT_MAX) m_flush++;
            if (frz) begin
                m_run++;
                if (m_run == MEM_TIMEOUT) begin
                    m_halted = 1; m_err = 1;
                end
            end else begin
                m_run = 0;
                if (hlt) m_halted = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        obs_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs", 32'({pc_en_o, fd_en_o, dx_en_o, xm_en_o, mw_en_o,
                      fd_clear_o, dx_clear_o, stall_cnt_o, flush_cnt_o, mem_err_o, halted_o}),
                      32'(e));
            end
            cycle++;
        end
    end

    initial begin : driver
        reset = 1; bubble_i = 0; branch_taken_i = 0; mem_req_i = 0; mem_ack_i = 0; halt_i = 0;

        // Reset with random inputs, then normal run.
        for (int i = 0; i < 2; i++)
            step(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        idle(1);
        // Single bubble, then branch overriding bubble.
        step(0, 1, 0, 0, 0, 0);
        idle(1);
        step(0, 1, 1, 0, 0, 0);
        idle(1);
        // 3-cycle memory access with branch held throughout; single-cycle access.
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 1, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        idle(1);
        // Timeout: request without ack until halted, then stay frozen.
        for (int i = 0; i < 7; i++) step(0, 0, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        idle(1);
        // Reset in the middle of a memory wait discards a pending ack.
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 1, 0);
        idle(1);
        // Halt from RUN, then held.
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0);
        idle(2);
        step(1, 0, 0, 0, 0, 0);
        // Stall counter saturation.
        for (int i = 0; i < 18; i++) step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // Randomized traffic with well-formed memory transactions.
        for (int i = 0; i < 600; i++) begin
            bit req, ack, rst;
            rst = m_halted && ($urandom_range(0, 3) == 0);
            if (rst) mem_left = 0;
            else if (mem_left == 0 && $urandom_range(0, 3) == 0) mem_left = $urandom_range(1, 6);
            req = (mem_left > 0);
            ack = (mem_left == 1);
            if (mem_left > 0) mem_left--;
            step(rst, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, req, ack,
                 $urandom_range(0, 40) == 0);
        end

        repeat (3) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
